// File: rtl/pwls_reg_write_arbiter.sv
// Round-robin arbiter that places host (FIFO) and sequencer (hold register) writes
// into ALU idle slots. Optional macro PWLS_ARB_COALESCE_EN: latest-wins sequencer hold.
module pwls_reg_write_arbiter #(
  parameter int REG_BITS   = 16,
  parameter int ADDR_BITS  = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 next_en,
  input  logic                 host_valid,
  output logic                 host_ready,
  input  logic [ADDR_BITS-1:0] host_addr,
  input  logic [REG_BITS-1:0]  host_data,
  input  logic                 host_state,
  input  logic                 seq_valid,
  output logic                 seq_ready,
  input  logic [ADDR_BITS-1:0] seq_addr,
  input  logic [REG_BITS-1:0]  seq_data,
  output logic [ADDR_BITS-1:0] reg_waddr,
  output logic [REG_BITS-1:0]  reg_wdata,
  output logic                 reg_we,
  output logic                 control_reg_write,
  output logic                 state_reg_write,
  output logic                 busy
`ifdef PWLS_ARB_COALESCE_EN
  ,
  output logic [15:0]          seq_drop_count
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [REG_BITS-1:0]  data;
    logic                 state;
  } host_entry_t;

  typedef enum logic {GRANT_HOST, GRANT_SEQ} src_e;

  host_entry_t          fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 hold_valid;
  logic [ADDR_BITS-1:0] hold_addr;
  logic [REG_BITS-1:0]  hold_data;
  src_e                 last_grant;

  logic        push, load, host_grant, seq_grant;
  host_entry_t head;

  assign head       = fifo_mem[rd_ptr];
  assign host_ready = !reset && (count < CNT_W'(FIFO_DEPTH));
`ifdef PWLS_ARB_COALESCE_EN
  assign seq_ready  = !reset;
`else
  assign seq_ready  = !reset && !hold_valid;
`endif
  assign push = host_valid && host_ready;
  assign load = seq_valid && seq_ready;
  assign busy = (count != '0) || hold_valid || reg_we;

  // NOTE: every variable gets a default first so no latch is inferred.
  always_comb begin
    host_grant = 1'b0;
    seq_grant  = 1'b0;
    if (!next_en) begin
      if ((count != '0) && hold_valid) begin
        host_grant = (last_grant == GRANT_SEQ);
        seq_grant  = (last_grant == GRANT_HOST);
      end else begin
        host_grant = (count != '0);
        seq_grant  = hold_valid;
      end
    end
  end

  // NOTE: FIFO storage is not reset; count/pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{addr: host_addr, data: host_data, state: host_state};
  end

  // NOTE: all sequential state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      hold_valid        <= 1'b0;
      hold_addr         <= '0;
      hold_data         <= '0;
      last_grant        <= GRANT_SEQ;
      reg_we            <= 1'b0;
      reg_waddr         <= '0;
      reg_wdata         <= '0;
      control_reg_write <= 1'b0;
      state_reg_write   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (host_grant) rd_ptr <= rd_ptr + 1'b1;
      case ({push, host_grant})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // A same-cycle load wins over the grant clear; the old value is still issued below.
      if (load) begin
        hold_valid <= 1'b1;
        hold_addr  <= seq_addr;
        hold_data  <= seq_data;
      end else if (seq_grant) begin
        hold_valid <= 1'b0;
      end

      reg_we            <= host_grant || seq_grant;
      control_reg_write <= host_grant && !head.state;
      state_reg_write   <= (host_grant && head.state) || seq_grant;
      if (host_grant) begin
        reg_waddr  <= head.addr;
        reg_wdata  <= head.data;
        last_grant <= GRANT_HOST;
      end else if (seq_grant) begin
        reg_waddr  <= hold_addr;
        reg_wdata  <= hold_data;
        last_grant <= GRANT_SEQ;
      end
    end
  end

`ifdef PWLS_ARB_COALESCE_EN
  // Counts sequencer writes overwritten before they reached the ALU.
  always_ff @(posedge clk) begin
    if (reset) begin
      seq_drop_count <= '0;
    end else if (load && hold_valid && !seq_grant && (seq_drop_count != 16'hFFFF)) begin
      seq_drop_count <= seq_drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pwls_reg_write_arbiter.sv
// Directed self-checking bench for pwls_reg_write_arbiter; inputs change 1 time unit
// after each rising edge, registered outputs are checked at the same point.
module tb_pwls_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        next_en;
  logic        host_valid, host_ready, host_state;
  logic [5:0]  host_addr;
  logic [15:0] host_data;
  logic        seq_valid, seq_ready;
  logic [5:0]  seq_addr;
  logic [15:0] seq_data;
  logic [5:0]  reg_waddr;
  logic [15:0] reg_wdata;
  logic        reg_we, control_reg_write, state_reg_write, busy;
`ifdef PWLS_ARB_COALESCE_EN
  logic [15:0] seq_drop_count;
`endif

  int checks = 0;
  int errors = 0;

  pwls_reg_write_arbiter #(.REG_BITS(16), .ADDR_BITS(6), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .next_en(next_en),
    .host_valid(host_valid), .host_ready(host_ready), .host_addr(host_addr),
    .host_data(host_data), .host_state(host_state),
    .seq_valid(seq_valid), .seq_ready(seq_ready), .seq_addr(seq_addr), .seq_data(seq_data),
    .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .control_reg_write(control_reg_write), .state_reg_write(state_reg_write), .busy(busy)
`ifdef PWLS_ARB_COALESCE_EN
    , .seq_drop_count(seq_drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_write(input string tag, input logic [5:0] addr, input logic [15:0] data,
                             input logic ctrl, input logic st);
    check({tag, ".we"}, 32'(reg_we), 32'd1);
    check({tag, ".addr"}, 32'(reg_waddr), 32'(addr));
    check({tag, ".data"}, 32'(reg_wdata), 32'(data));
    check({tag, ".ctrl"}, 32'(control_reg_write), 32'(ctrl));
    check({tag, ".state"}, 32'(state_reg_write), 32'(st));
  endtask

  task automatic host_push(input logic [5:0] a, input logic [15:0] d, input logic s);
    host_valid = 1'b1; host_addr = a; host_data = d; host_state = s;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    int accepted;
    int exp_idx;
    reset = 1'b1; next_en = 1'b0;
    host_valid = 1'b0; host_addr = '0; host_data = '0; host_state = 1'b0;
    seq_valid = 1'b0; seq_addr = '0; seq_data = '0;

    // Reset state
    tick();
    tick();
    check("rst.we", 32'(reg_we), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.waddr", 32'(reg_waddr), 32'd0);
    check("rst.host_ready", 32'(host_ready), 32'd0);
    check("rst.seq_ready", 32'(seq_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("rst.host_ready_rel", 32'(host_ready), 32'd1);

    // 1: single host write reaches the ALU two cycles after the push
    host_push(6'h05, 16'h1234, 1'b0);
    tick();
    host_valid = 1'b0;
    check("t1.we_early", 32'(reg_we), 32'd0);
    check("t1.busy", 32'(busy), 32'd1);
    tick();
    check_write("t1.wr", 6'h05, 16'h1234, 1'b1, 1'b0);
    tick();
    check("t1.pulse", 32'(reg_we), 32'd0);
    check("t1.addr_hold", 32'(reg_waddr), 32'h05);
    check("t1.busy_end", 32'(busy), 32'd0);

    // 2: fill FIFO while ALU busy, then drain in order
    next_en = 1'b1;
    accepted = 0;
    for (int i = 0; i < 5; i++) begin
      host_push(6'(i), 16'h0100 + 16'(i), 1'b0);
      check($sformatf("t2.ready%0d", i), 32'(host_ready), (i < 4) ? 32'd1 : 32'd0);
      if (host_ready) accepted++;
      tick();
    end
    host_valid = 1'b0;
    check("t2.accepted", 32'(accepted), 32'd4);
    check("t2.full", 32'(host_ready), 32'd0);
    check("t2.no_we", 32'(reg_we), 32'd0);
    next_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_write($sformatf("t2.wr%0d", i), 6'(i), 16'h0100 + 16'(i), 1'b1, 1'b0);
      if (i == 0) check("t2.ready_back", 32'(host_ready), 32'd1);
    end
    tick();
    check("t2.drained", 32'(reg_we), 32'd0);
    check("t2.busy_end", 32'(busy), 32'd0);

    // 3: round-robin between host and sequencer, host wins the first tie after reset
    do_reset();
    next_en = 1'b1;
    host_push(6'h20, 16'hA000, 1'b1);
    seq_valid = 1'b1; seq_addr = 6'h30; seq_data = 16'hB000;
    tick();
    seq_valid = 1'b0;
    host_push(6'h21, 16'hA001, 1'b0);
`ifndef PWLS_ARB_COALESCE_EN
    check("t3.seq_ready_held", 32'(seq_ready), 32'd0);
`endif
    tick();
    host_valid = 1'b0;
    next_en = 1'b0;
    tick();
    check_write("t3.host0", 6'h20, 16'hA000, 1'b0, 1'b1);
    tick();
    check_write("t3.seq", 6'h30, 16'hB000, 1'b0, 1'b1);
    tick();
    check_write("t3.host1", 6'h21, 16'hA001, 1'b1, 1'b0);
    tick();
    check("t3.idle", 32'(reg_we), 32'd0);
    check("t3.seq_ready_back", 32'(seq_ready), 32'd1);

    // 4: next_en toggling; writes only after next_en=0 samples, none lost or duplicated
    next_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      host_push(6'h08 + 6'(i), 16'hC000 + 16'(i), 1'b0);
      tick();
    end
    host_valid = 1'b0;
    exp_idx = 0;
    for (int k = 0; k < 8; k++) begin
      next_en = k[0];
      tick();
      if (k[0] == 1'b0 && exp_idx < 3) begin
        check_write($sformatf("t4.wr%0d", exp_idx), 6'h08 + 6'(exp_idx),
                    16'hC000 + 16'(exp_idx), 1'b1, 1'b0);
        exp_idx++;
      end else begin
        check($sformatf("t4.gap%0d", k), 32'(reg_we), 32'd0);
      end
    end
    check("t4.busy_end", 32'(busy), 32'd0);

    // 5: reset mid-stream discards pending work
    next_en = 1'b1;
    seq_valid = 1'b1; seq_addr = 6'h31; seq_data = 16'hD000;
    for (int i = 0; i < 3; i++) begin
      host_push(6'h10 + 6'(i), 16'hE000 + 16'(i), 1'b1);
      tick();
      seq_valid = 1'b0;
    end
    host_valid = 1'b0;
    check("t5.busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    next_en = 1'b0;
    tick();
    check("t5.we_rst", 32'(reg_we), 32'd0);
    check("t5.busy_rst", 32'(busy), 32'd0);
    reset = 1'b0;
    #1;
    check("t5.host_ready", 32'(host_ready), 32'd1);
    check("t5.seq_ready", 32'(seq_ready), 32'd1);
    tick();
    check("t5.we_after0", 32'(reg_we), 32'd0);
    tick();
    check("t5.we_after1", 32'(reg_we), 32'd0);
    check("t5.busy_after", 32'(busy), 32'd0);

`ifdef PWLS_ARB_COALESCE_EN
    // 6: latest sequencer write wins, one drop counted
    next_en = 1'b1;
    seq_valid = 1'b1; seq_addr = 6'h10; seq_data = 16'hAAAA;
    tick();
    seq_data = 16'hBBBB;
    tick();
    seq_valid = 1'b0;
    check("t6.drops", 32'(seq_drop_count), 32'd1);
    next_en = 1'b0;
    tick();
    check_write("t6.wr", 6'h10, 16'hBBBB, 1'b0, 1'b1);
    tick();
    check("t6.single", 32'(reg_we), 32'd0);
    check("t6.busy_end", 32'(busy), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwls_reg_write_arbiter.md
Name: pwls_reg_write_arbiter

Overview:
Shares the register write port of pwls_multichannel_ALU_unit between two requesters:
- the host register interface, buffered in a FIFO;
- the autonomous sweep/envelope sequencer, buffered in a single-entry hold register.
Writes are issued only into ALU idle slots (next_en low) and arbitrated round-robin. Outputs drive reg_waddr, reg_wdata, reg_we, control_reg_write and state_reg_write of the ALU unit directly.

Parameters:
REG_BITS, 16, register write data width (matches `REG_BITS)
ADDR_BITS, 6, register address width
FIFO_DEPTH, 4, host FIFO entries; power of two, >= 2

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
next_en  in  1  ALU enable for the next cycle; a write may be launched only when 0
host_valid  in  1  host write request
host_ready  out  1  host FIFO can accept
host_addr  in  ADDR_BITS  host register address
host_data  in  REG_BITS  host write data
host_state  in  1  1 = state register write, 0 = control register write
seq_valid  in  1  sequencer write request
seq_ready  out  1  sequencer hold register can accept
seq_addr  in  ADDR_BITS  sequencer register address
seq_data  in  REG_BITS  sequencer write data
reg_waddr  out  ADDR_BITS  to ALU
reg_wdata  out  REG_BITS  to ALU
reg_we  out  1  to ALU, single-cycle pulse
control_reg_write  out  1  to ALU, qualifies reg_we
state_reg_write  out  1  to ALU, qualifies reg_we
busy  out  1  FIFO non-empty, hold valid, or reg_we high

Behaviour:
- Reset (sync, active-high):
  - FIFO empty; hold register invalid; last_grant = SEQ, so the host wins the first tie.
  - reg_we, reg_waddr, reg_wdata, control_reg_write, state_reg_write, busy all 0.
  - host_ready = 0 and seq_ready = 0 while reset is high.
- Host push: on host_valid && host_ready. host_ready = !reset && count < FIFO_DEPTH, derived from registered count only.
  - When the FIFO is full, host_ready = 0 even if a pop occurs in the same cycle.
  - Each entry stores {addr, data, state}.
- Sequencer load: on seq_valid && seq_ready. Without the optional feature, seq_ready = !reset && !hold_valid, so the hold register cannot be refilled in the cycle it is granted.
- Slot decision, in cycle t when next_en == 0 and at least one source is pending:
  - Only one source pending: grant it.
  - Both pending: grant the source != last_grant. Update last_grant.
  - The granted entry is popped/cleared in cycle t.
- Launch timing:
  - Outputs are registered. For a grant in cycle t, at cycle t+1: reg_we = 1 and reg_waddr/reg_wdata hold the granted values.
  - Host grant: control_reg_write = !state, state_reg_write = state.
  - Sequencer grant: control_reg_write = 0, state_reg_write = 1.
- No grant in cycle t: at t+1, reg_we, control_reg_write and state_reg_write are 0; reg_waddr and reg_wdata hold their previous values.
- Maximum one write per cycle. Back-to-back writes occur while next_en stays 0.
- Latency: an entry pushed at cycle t is first eligible at t+1, reaching the ALU at t+2 at the earliest.
- Same-cycle push and pop on a non-full FIFO: count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Reset asserted mid-stream: pending entries are discarded. reg_we is 0 in the cycle after reset is sampled.
- Write ordering: host writes are issued in FIFO order. There is no ordering between the host and sequencer streams.

Optional Feature:
PWLS_ARB_COALESCE_EN
- Defined:
  - seq_ready = !reset, constant 1 outside reset.
  - A sequencer load while hold_valid replaces the hold contents (latest write wins), including in the cycle the old contents are granted; the granted old value is still issued.
  - A 16-bit saturating output seq_drop_count counts overwrites of ungranted entries; reset to 0.
- Undefined: seq_ready behaves as above and port seq_drop_count does not exist.

Test Plan:
1. Reset then next_en=0; host push addr=0x05 data=0x1234 state=0 -> two cycles later reg_we=1 for 1 cycle, reg_waddr=0x05, reg_wdata=0x1234, control_reg_write=1, state_reg_write=0.
2. Hold next_en=1; push 5 host writes -> host_ready falls after 4 accepts. Release next_en=0 -> 4 writes issue on consecutive cycles in order; host_ready returns 1 one cycle after the first pop.
3. Host FIFO and hold both pending, next_en=0 -> grants host, seq, host, ...; sequencer writes show state_reg_write=1, control_reg_write=0.
4. next_en toggles 0/1 every cycle with 3 host writes queued -> reg_we high only in cycles following next_en=0 samples; no write is lost or duplicated.
5. Reset asserted with 3 entries queued and 1 in hold -> after reset, reg_we stays 0, busy=0, host_ready=1.
6. With PWLS_ARB_COALESCE_EN, next_en=1, seq writes 0x10/0xAAAA then 0x10/0xBBBB -> seq_drop_count=1. After next_en=0, exactly one write of 0xBBBB is issued.
